// File: rtl/sp1_ff_wr_arb.sv
// sp1_ff_wr_arb: round-robin write arbiter in front of one shared sp1_ff register.
// NREQ requesters offer a word each. One winner per arbitration gets a one-cycle
// ff_en/ff_d write. Its ack pulses in the following cycle, when q already holds the data.
// Optional build macro: SP1_FF_WR_ARB_FIXPRI_EN selects fixed priority, where the
// lowest index wins, in place of round-robin.
module sp1_ff_wr_arb #(
  parameter int DW   = 32,
  parameter int NREQ = 4,
  parameter int IW   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DW-1:0]   wdata,
  output logic [NREQ-1:0]      ack,
  output logic                 ff_en,
  output logic [DW-1:0]        ff_d,
  output logic [IW-1:0]        gnt_id,
  output logic                 busy
);

  // Internal vectors are padded to 2**IW slots, so any IW-bit index is in range.
  localparam int NSLOT = 2**IW;

  typedef enum logic [1:0] {IDLE, WRITE, ACK} state_t;

  state_t             state;
  logic [NSLOT-1:0]   gnt_mask;
  logic [NSLOT-1:0]   req_ext;
  logic [NSLOT-1:0]   cand;
  logic [DW-1:0]      wdata_arr [NSLOT];
  logic [IW-1:0]      win;
  logic               found;
  logic               any;

  // Per-slot views: one-hot of the current grant, padded requests and data words.
  generate
    for (genvar gi = 0; gi < NSLOT; gi++) begin : g_slot
      assign gnt_mask[gi] = (gnt_id == IW'(gi));
      if (gi < NREQ) begin : g_live
        assign req_ext[gi]   = req[gi];
        assign wdata_arr[gi] = wdata[gi*DW +: DW];
      end else begin : g_pad
        assign req_ext[gi]   = 1'b0;
        assign wdata_arr[gi] = '0;
      end
    end
  endgenerate

  // In ACK, the acked requester still holds req. Its bit is masked so that it
  // is not counted as a new request.
  assign cand = (state == ACK) ? (req_ext & ~gnt_mask) : req_ext;
  assign any  = |cand;

`ifdef SP1_FF_WR_ARB_FIXPRI_EN
  // Fixed priority: the lowest set candidate wins.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < NSLOT; k++) begin
      if (!found && cand[k]) begin
        win   = IW'(k);
        found = 1'b1;
      end
    end
  end
`else
  logic [IW-1:0] last;
  logic [IW-1:0] idx;

  // Round-robin: search from last+1 and wrap. last itself is checked at the end,
  // so it wins only when it is the sole candidate.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IW'((int'(last) + k) % NREQ);
      if (!found && cand[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end
`endif

  // Arbitration FSM. All outputs are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      ack    <= '0;
      ff_en  <= 1'b0;
      ff_d   <= '0;
      gnt_id <= '0;
      busy   <= 1'b0;
`ifndef SP1_FF_WR_ARB_FIXPRI_EN
      last   <= IW'(NREQ-1);
`endif
    end else begin
      case (state)
        IDLE: begin
          ack <= '0;
          if (any) begin
            ff_d   <= wdata_arr[win];
            ff_en  <= 1'b1;
            gnt_id <= win;
            busy   <= 1'b1;
            state  <= WRITE;
          end
        end
        WRITE: begin
          // The register captures ff_d on this edge, so the ack can go out next.
          ff_en <= 1'b0;
          ack   <= gnt_mask[NREQ-1:0];
`ifndef SP1_FF_WR_ARB_FIXPRI_EN
          last  <= gnt_id;
`endif
          state <= ACK;
        end
        ACK: begin
          ack <= '0;
          if (any) begin
            ff_d   <= wdata_arr[win];
            ff_en  <= 1'b1;
            gnt_id <= win;
            state  <= WRITE;
          end else begin
            busy   <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          ack   <= '0;
          ff_en <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sp1_ff_wr_arb.sv
// Testbench for sp1_ff_wr_arb. Directed vectors push the expected (winner, data)
// pairs into a scoreboard. A monitor pops and checks one entry at every ack pulse,
// using a local model of the sp1_ff register.
module tb_sp1_ff_wr_arb;
  localparam int DW = 32;
  localparam int NREQ = 4;
  localparam int IW = 3;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req;
  logic [NREQ*DW-1:0]  wdata;
  logic [NREQ-1:0]     ack;
  logic                ff_en;
  logic [DW-1:0]       ff_d;
  logic [IW-1:0]       gnt_id;
  logic                busy;

  logic [DW-1:0]       q = '0;
  logic [NREQ-1:0]     drop_pend;
  int                  cyc = 0;
  int                  ack_cyc [NREQ];
  int                  n_checks = 0;
  int                  n_errors = 0;

  typedef struct {
    int          id;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  sp1_ff_wr_arb #(.DW(DW), .NREQ(NREQ), .IW(IW)) dut (
    .clk(clk), .rst(rst), .req(req), .wdata(wdata), .ack(ack),
    .ff_en(ff_en), .ff_d(ff_d), .gnt_id(gnt_id), .busy(busy)
  );

  always #5 clk = ~clk;

  // Model of the controlled sp1_ff register and a cycle counter.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ff_en) q <= ff_d;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input int id, input logic [31:0] data);
    exp_t e;
    e.id = id;
    e.data = data;
    sb.push_back(e);
  endtask

  // Advance n cycles. A requester drops req in the cycle after its ack unless it is held.
  task automatic run(input int n, input logic [NREQ-1:0] hold);
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      req = req & ~(drop_pend & ~hold);
      drop_pend = ack;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    req = '0;
    drop_pend = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Monitor: checks exclusivity and pops the scoreboard on every ack pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (ff_en || (ack != '0)) begin
        n_checks++;
        if (ff_en && (ack != '0)) begin
          n_errors++;
          $display("FAIL en_ack_excl: ff_en=%b ack=%b, expected not both", ff_en, ack);
        end
      end
      if (ack != '0) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_ack: ack=%b, expected none", ack);
        end else begin
          exp_t e;
          logic [NREQ-1:0] exp_ack;
          e = sb.pop_front();
          exp_ack = '0;
          exp_ack[e.id] = 1'b1;
          $display("ack cyc=%0d ack=%b gnt_id=%0d q=%h (expect id %0d data %h)",
                   cyc, ack, gnt_id, q, e.id, e.data);
          chk("ack_vec", 32'(ack), 32'(exp_ack));
          chk("gnt_id", 32'(gnt_id), 32'(e.id));
          chk("q_at_ack", q, e.data);
          ack_cyc[e.id] = cyc;
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    req = '0;
    wdata = '0;
    drop_pend = '0;
    for (int i = 0; i < NREQ; i++) ack_cyc[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_ff_en", 32'(ff_en), 32'h0);
    chk("rst_ff_d", ff_d, 32'h0);
    chk("rst_gnt_id", 32'(gnt_id), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);

    // 1: single request right after reset release, 2-cycle latency
    wdata[0*DW +: DW] = 32'hA5A5_0001;
    push(0, 32'hA5A5_0001);
    rst = 1'b0;
    req = 4'b0001;
    @(posedge clk); #1;
    chk("t1_ff_en", 32'(ff_en), 32'h1);
    chk("t1_ff_d", ff_d, 32'hA5A5_0001);
    chk("t1_busy", 32'(busy), 32'h1);
    chk("t1_no_ack_yet", 32'(ack), 32'h0);
    @(posedge clk); #1;
    chk("t1_ack", 32'(ack), 32'h1);
    chk("t1_ff_en_off", 32'(ff_en), 32'h0);
    chk("t1_q", q, 32'hA5A5_0001);
    drop_pend = ack;
    run(3, 4'b0000);
    chk("t1_idle_busy", 32'(busy), 32'h0);

    // 2: two simultaneous requests, acks two cycles apart
    do_reset();
    wdata[0*DW +: DW] = 32'h1111_0000;
    wdata[1*DW +: DW] = 32'h2222_0001;
    push(0, 32'h1111_0000);
    push(1, 32'h2222_0001);
    req = 4'b0011;
    run(6, 4'b0000);
    chk("t2_ack_spacing", 32'(ack_cyc[1] - ack_cyc[0]), 32'd2);
    chk("t2_q_final", q, 32'h2222_0001);
    chk("t2_busy", 32'(busy), 32'h0);

    // 3: all four held; rotation with no starvation
    do_reset();
    for (int i = 0; i < NREQ; i++) wdata[i*DW +: DW] = 32'h3000_0000 + 32'(i);
`ifdef SP1_FF_WR_ARB_FIXPRI_EN
    for (int i = 0; i < 6; i++) push(i % 2, 32'h3000_0000 + 32'(i % 2));
`else
    for (int i = 0; i < 6; i++) push(i % 4, 32'h3000_0000 + 32'(i % 4));
`endif
    req = 4'b1111;
    run(12, 4'b1111);
    req = '0;
    run(3, 4'b0000);

    // 4: req1 stays high through its ACK; req2 is served before req1 again
    do_reset();
    wdata[1*DW +: DW] = 32'h4000_0001;
    wdata[2*DW +: DW] = 32'h4000_0002;
    push(1, 32'h4000_0001);
    push(2, 32'h4000_0002);
    push(1, 32'h4000_0001);
    req = 4'b0110;
    run(6, 4'b0010);
    req = '0;
    run(3, 4'b0000);

    // 5: async reset during WRITE
    do_reset();
    wdata[0*DW +: DW] = 32'h5000_0000;
    wdata[2*DW +: DW] = 32'h5000_0002;
    req = 4'b0100;
    @(posedge clk); #1;
    chk("t5_ff_en_pre", 32'(ff_en), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_ff_en_async", 32'(ff_en), 32'h0);
    chk("t5_busy_async", 32'(busy), 32'h0);
    chk("t5_ack_async", 32'(ack), 32'h0);
    chk("t5_gnt_async", 32'(gnt_id), 32'h0);
    @(posedge clk); #1;
    chk("t5_q_unchanged", q, 32'h4000_0001);
    rst = 1'b0;
    drop_pend = '0;
    push(0, 32'h5000_0000);
    push(2, 32'h5000_0002);
    req = 4'b0101;
    run(6, 4'b0000);
    chk("t5_q_final", q, 32'h5000_0002);

    // 6: req 1010 held; 1 and 3 alternate because the acked bit is masked
    do_reset();
    wdata[1*DW +: DW] = 32'h6000_0001;
    wdata[3*DW +: DW] = 32'h6000_0003;
    push(1, 32'h6000_0001);
    push(3, 32'h6000_0003);
    push(1, 32'h6000_0001);
    push(3, 32'h6000_0003);
    req = 4'b1010;
    run(8, 4'b1010);
    req = '0;
    run(3, 4'b0000);

    chk("sb_drained", 32'(sb.size()), 32'h0);
    chk("end_busy", 32'(busy), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
